pgr_uart_rx_32bit: RTL and testbench

//  UART receiver for the uart2apb bridge; the RX counterpart of the bridge's UART transmitter.

---
 rtl/pgr_uart_pkg.sv | 31 +++
 rtl/pgr_uart_rx_sampler.sv | 48 ++++
 rtl/pgr_uart_rx_32bit.sv | 176 +++++++++++++++++
 tb/tb_pgr_uart_rx_32bit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgr_uart_pkg.sv
// Shared UART definitions for the uart2apb bridge RX/TX pair: FSM states, word-length
// encoding, default oversample ratio and the parity function both directions agree on.
package pgr_uart_pkg;

  localparam int UART_OSR = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic [1:0] {
    WL_5 = 2'b00,
    WL_6 = 2'b01,
    WL_7 = 2'b10,
    WL_8 = 2'b11
  } uart_wlen_e;

  // Unused upper bits of data must be zero; they then do not disturb the reduction.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

  function automatic logic [2:0] uart_last_bit(input logic [1:0] wlen);
    return 3'd4 + {1'b0, wlen};
  endfunction

endpackage

// File: rtl/pgr_uart_rx_sampler.sv
// rxd synchroniser, tick-rate last-sample register, falling-edge detect and 3-sample majority vote.
// Edge and vote are combinational off registered samples; no backpressure.
module pgr_uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic rxd,
  input  logic cap_a,
  input  logic cap_b,
  output logic fall_edge,
  output logic vote
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   smp_a_q;
  logic                   smp_b_q;
  logic                   rxd_sync;

  assign rxd_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      last_q  <= 1'b1;
      smp_a_q <= 1'b1;
      smp_b_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      if (clk_en) begin
        last_q <= rxd_sync;
      end
      if (cap_a) begin
        smp_a_q <= rxd_sync;
      end
      if (cap_b) begin
        smp_b_q <= rxd_sync;
      end
    end
  end

  // A held-low line (break) keeps last_q at 0, so no new edge until rxd returns high.
  assign fall_edge = clk_en & last_q & ~rxd_sync;
  assign vote      = (smp_a_q & smp_b_q) | (smp_a_q & rxd_sync) | (smp_b_q & rxd_sync);

endmodule

// File: rtl/pgr_uart_rx_32bit.sv
// UART RX de-framer (OSR-x oversampled, 5..8 data bits, optional parity, 1/2 stop, LSB/MSB first).
// Write strobe 1 clk after the last stop-bit vote; a full FIFO drops the frame and pulses overrun.
module pgr_uart_rx_32bit
  import pgr_uart_pkg::*;
#(
  parameter int OSR         = UART_OSR,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       rxd,
  input  logic [1:0] uart_word_len,
  input  logic       uart_parity_en,
  input  logic       uart_parity_type,
  input  logic       uart_stop_len,
  input  logic       uart_mode,
  input  logic       rx_fifo_full,
  output logic [7:0] rx_fifo_wr_data,
  output logic       rx_fifo_wr_en,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int TW = (OSR > 1) ? $clog2(OSR) : 1;

  uart_state_e   state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    shift_q;
  logic          par_err_q;
  logic          frm_err_q;

  logic [7:0]    wr_data_q;
  logic          wr_en_q;
  logic          par_pulse_q;
  logic          frm_pulse_q;
  logic          ovr_q;

  logic          fall_edge;
  logic          vote;
  logic          last_tick;
  logic          at_vote;
  logic          cap_a;
  logic          cap_b;
  logic          stop_bad;
  logic [1:0]    align_sh;
  logic [7:0]    data_aligned;

  assign last_tick = (tick_q == TW'(OSR - 1));
  assign at_vote   = (tick_q == TW'(4));
  assign cap_a     = clk_en && (tick_q == TW'(2));
  assign cap_b     = clk_en && (tick_q == TW'(3));

  // LSB-first fills from the top, so short words sit high until shifted down.
  assign align_sh     = 2'd3 - uart_word_len;
  assign data_aligned = uart_mode ? shift_q : (shift_q >> align_sh);
  assign stop_bad     = frm_err_q | ~vote;

  pgr_uart_rx_sampler #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .rxd       (rxd),
    .cap_a     (cap_a),
    .cap_b     (cap_b),
    .fall_edge (fall_edge),
    .vote      (vote)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      par_pulse_q <= 1'b0;
      frm_pulse_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      par_pulse_q <= 1'b0;
      frm_pulse_q <= 1'b0;
      ovr_q       <= 1'b0;

      if (clk_en) begin
        tick_q <= last_tick ? '0 : tick_q + TW'(1);

        case (state_q)
          ST_IDLE: begin
            if (fall_edge) begin
              state_q <= ST_START;
              tick_q  <= TW'(1);
            end
          end

          ST_START: begin
            if (at_vote && vote) begin
              state_q <= ST_IDLE;
            end else if (last_tick) begin
              state_q   <= ST_DATA;
              bit_q     <= '0;
              shift_q   <= '0;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end
          end

          ST_DATA: begin
            if (at_vote) begin
              shift_q <= uart_mode ? {shift_q[6:0], vote} : {vote, shift_q[7:1]};
            end
            if (last_tick) begin
              if (bit_q == uart_last_bit(uart_word_len)) begin
                state_q <= uart_parity_en ? ST_PARITY : ST_STOP;
                stop_q  <= 1'b0;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end
          end

          ST_PARITY: begin
            if (at_vote) begin
              par_err_q <= vote ^ uart_parity(data_aligned, uart_parity_type);
            end
            if (last_tick) begin
              state_q <= ST_STOP;
              stop_q  <= 1'b0;
            end
          end

          ST_STOP: begin
            // Leave mid-stop on the last vote so a start edge half a bit later is caught.
            if (at_vote) begin
              if (stop_q == uart_stop_len) begin
                state_q <= ST_IDLE;
                if (!rx_fifo_full) begin
                  wr_en_q     <= 1'b1;
                  wr_data_q   <= data_aligned;
                  par_pulse_q <= par_err_q;
                  frm_pulse_q <= stop_bad;
                end else begin
                  ovr_q <= 1'b1;
                end
              end else begin
                frm_err_q <= stop_bad;
              end
            end
            if (last_tick) begin
              stop_q <= 1'b1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_fifo_wr_data = wr_data_q;
  assign rx_fifo_wr_en   = wr_en_q;
  assign rx_parity_err   = par_pulse_q;
  assign rx_frame_err    = frm_pulse_q;
  assign rx_overrun      = ovr_q;

endmodule

// File: tb/tb_pgr_uart_rx_32bit.sv
// Directed bench for pgr_uart_rx_32bit: a bit-level TX drives rxd, a frame-level model
// queues the expected FIFO events, and one compare process checks every output cycle.
`timescale 1ns/1ps
module tb_pgr_uart_rx_32bit;

  localparam int OSR = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] uart_word_len = 2'b11;
  logic       uart_parity_en = 1'b0;
  logic       uart_parity_type = 1'b0;
  logic       uart_stop_len = 1'b0;
  logic       uart_mode = 1'b0;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] rx_fifo_wr_data;
  logic       rx_fifo_wr_en;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  int overruns_seen = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t expq[$];
  exp_t cur;

  pgr_uart_rx_32bit #(
    .OSR         (OSR),
    .SYNC_STAGES (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clk_en           (clk_en),
    .rxd              (rxd),
    .uart_word_len    (uart_word_len),
    .uart_parity_en   (uart_parity_en),
    .uart_parity_type (uart_parity_type),
    .uart_stop_len    (uart_stop_len),
    .uart_mode        (uart_mode),
    .rx_fifo_full     (rx_fifo_full),
    .rx_fifo_wr_data  (rx_fifo_wr_data),
    .rx_fifo_wr_en    (rx_fifo_wr_en),
    .rx_parity_err    (rx_parity_err),
    .rx_frame_err     (rx_frame_err),
    .rx_overrun       (rx_overrun)
  );

  always #5 clk = ~clk;

  // One-clk-wide baud*OSR tick every 4 clocks.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 clk_en = 1'b1;
      @(posedge clk);
      #1 clk_en = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (clk_en !== 1'b1);
  endtask

  // Frame-level model: word is the low n bits; parity bit makes the total count even/odd.
  function automatic logic [7:0] model_word(input logic [7:0] b, input logic [1:0] wl);
    int n;
    logic [7:0] w;
    n = int'(wl) + 5;
    w = 8'h00;
    for (int i = 0; i < n; i++) w[i] = b[i];
    return w;
  endfunction

  function automatic logic model_par(input logic [7:0] w, input logic odd);
    int ones;
    ones = $countones(w);
    return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_bit(input logic b);
    #1 rxd = b;
    repeat (OSR) wait_tick();
  endtask

  task automatic send_idle(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop0);
    int n;
    logic [7:0] w;
    logic pb;
    exp_t fe;
    n  = int'(uart_word_len) + 5;
    w  = model_word(b, uart_word_len);
    pb = model_par(w, uart_parity_type) ^ flip_par;
    fe.data = w;
    fe.ovr  = rx_fifo_full;
    fe.perr = !rx_fifo_full && uart_parity_en && flip_par;
    fe.ferr = !rx_fifo_full && stop0;
    expq.push_back(fe);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(uart_mode ? w[n-1-i] : w[i]);
    if (uart_parity_en) send_bit(pb);
    if (uart_stop_len) send_bit(~stop0);
    // Last stop bit: the FIFO event must appear one clk after its 5th tick (rx tick 4).
    #1 rxd = ~stop0;
    repeat (5) wait_tick();
    @(negedge clk);
    chk("wr_latency", {31'd0, rx_fifo_wr_en | rx_overrun}, 32'd1);
    wait_tick();
  endtask

  task automatic set_cfg(input logic [1:0] wl, input logic pen, input logic ptype,
                         input logic stop2, input logic msbf);
    #1;
    uart_word_len    = wl;
    uart_parity_en   = pen;
    uart_parity_type = ptype;
    uart_stop_len    = stop2;
    uart_mode        = msbf;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rx_fifo_wr_en || rx_overrun) begin
        if (expq.size() == 0) begin
          chk("unexpected_event_queue", 32'(expq.size()), 32'd1);
        end else begin
          cur = expq.pop_front();
          chk("wr_en", {31'd0, rx_fifo_wr_en}, {31'd0, !cur.ovr});
          chk("overrun", {31'd0, rx_overrun}, {31'd0, cur.ovr});
          if (!cur.ovr) chk("wr_data", {24'd0, rx_fifo_wr_data}, {24'd0, cur.data});
          chk("parity_err", {31'd0, rx_parity_err}, {31'd0, cur.perr});
          chk("frame_err", {31'd0, rx_frame_err}, {31'd0, cur.ferr});
          if (rx_fifo_wr_en) begin
            writes_seen++;
            last_data = rx_fifo_wr_data;
            last_perr = rx_parity_err;
            last_ferr = rx_frame_err;
          end
          if (rx_overrun) overruns_seen++;
        end
      end else if (rx_parity_err || rx_frame_err) begin
        chk("stray_err_pulse", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);
      end
    end
  end

  initial begin
    int w0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", {31'd0, rx_fifo_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, rx_fifo_wr_data}, 32'd0);
    chk("rst_parity_err", {31'd0, rx_parity_err}, 32'd0);
    chk("rst_frame_err", {31'd0, rx_frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    rst_n = 1'b1;
    wait_tick();
    send_idle(2);

    chk("model_word_5bit", {24'd0, model_word(8'hF3, 2'b00)}, 32'h13);
    chk("model_par_even_13", {31'd0, model_par(8'h13, 1'b0)}, 32'd1);
    chk("model_par_odd_3c", {31'd0, model_par(8'h3C, 1'b1)}, 32'd1);

    // 8N1 LSB first
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    send_idle(1);
    chk("t1_data", {24'd0, last_data}, 32'hA5);
    chk("t1_writes", 32'(writes_seen), 32'd1);

    // 5E2 MSB first, good then flipped parity
    set_cfg(2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h13, 1'b0, 1'b0);
    send_idle(1);
    chk("t2_data", {24'd0, last_data}, 32'h13);
    chk("t2_perr_clean", {31'd0, last_perr}, 32'd0);
    send_frame(8'h13, 1'b1, 1'b0);
    send_idle(1);
    chk("t2_data_flip", {24'd0, last_data}, 32'h13);
    chk("t2_perr_flip", {31'd0, last_perr}, 32'd1);

    // 7O1 back to back, no idle gap
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    w0 = writes_seen;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h41, 1'b0, 1'b0);
    send_idle(1);
    chk("t3_writes", 32'(writes_seen - w0), 32'd2);
    chk("t3_last_data", {24'd0, last_data}, 32'h41);

    // 8N1 stop forced low, then a one-tick glitch while idle
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1);
    send_idle(2);
    chk("t4_data", {24'd0, last_data}, 32'h96);
    chk("t4_ferr", {31'd0, last_ferr}, 32'd1);
    w0 = writes_seen;
    #1 rxd = 1'b0;
    wait_tick();
    #1 rxd = 1'b1;
    repeat (3 * OSR) wait_tick();
    chk("t4_glitch_no_write", 32'(writes_seen), 32'(w0));

    // FIFO full at write time, then recovery
    #1 rx_fifo_full = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0);
    #1 rx_fifo_full = 1'b0;
    send_idle(1);
    chk("t5_overruns", 32'(overruns_seen), 32'd1);
    send_frame(8'h7E, 1'b0, 1'b0);
    send_idle(1);
    chk("t5_data_after", {24'd0, last_data}, 32'h7E);

    // Reset in the middle of the data bits
    w0 = writes_seen;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_wr_en", {31'd0, rx_fifo_wr_en}, 32'd0);
    chk("t6_rst_wr_data", {24'd0, rx_fifo_wr_data}, 32'd0);
    chk("t6_rst_errs", {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 32'd0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    send_idle(2);
    chk("t6_no_aborted_write", 32'(writes_seen), 32'(w0));
    send_frame(8'h5A, 1'b0, 1'b0);
    send_idle(1);
    chk("t6_data", {24'd0, last_data}, 32'h5A);
    chk("t6_writes", 32'(writes_seen - w0), 32'd1);

    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
